// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, register-index
// width and the per-register control bundle.
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_e;

  // en/flush index order: [3]=IF_ID, [2]=ID_EX, [1]=EX_MEM, [0]=MEM_WB
  typedef struct packed {
    logic       pc_en;
    logic       pc_src;
    logic [3:0] en;
    logic [3:0] flush;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{pc_en: 1'b0, pc_src: 1'b0, en: 4'b0000, flush: 4'b0000};
  localparam ctrl_t CTRL_RUN  = '{pc_en: 1'b1, pc_src: 1'b0, en: 4'b1111, flush: 4'b0000};

endpackage

// File: rtl/pipe_hazard_ctrl_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX.
module pipe_hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_wreg_i,
  output logic             load_use_o
);

  logic rs_hit;
  logic rt_hit;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign rs_hit     = (ex_wreg_i == id_rs_i);
  assign rt_hit     = id_uses_rt_i && (ex_wreg_i == id_rt_i);
  assign load_use_o = ex_memread_i && (ex_wreg_i != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional performance counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int REG_W       = pipe_pkg::REG_W,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_wreg,
  input  logic             ex_mem_branch,
  input  logic             ex_mem_zero,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_src,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] memwait_cycles,
`endif
  output logic             timeout_err
);

  import pipe_pkg::*;

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_err_q, timeout_err_d;
  logic            load_use, mem_wait, timeout_hit, stall_mem, branch_taken, lu_stall;
  ctrl_t           ctrl;

  pipe_hazard_detect #(.REG_W(REG_W)) u_detect (
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rt_i (id_uses_rt),
    .ex_memread_i (id_ex_memread),
    .ex_wreg_i    (id_ex_wreg),
    .load_use_o   (load_use)
  );

  always_comb begin
    // Once waiting, only dmem_ready releases the stall.
    mem_wait      = (state_q == S_MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);
    timeout_hit   = mem_wait && (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1));
    stall_mem     = mem_wait && !timeout_hit;
    branch_taken  = ex_mem_branch && ex_mem_zero && !stall_mem;
    lu_stall      = load_use && !stall_mem && !branch_taken;
    ctrl          = CTRL_RUN;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    if (stall_mem) begin
      ctrl.pc_en    = 1'b0;
      ctrl.en[3:1]  = 3'b000;
      ctrl.flush[0] = 1'b1;
      state_d       = S_MEM_WAIT;
      wait_cnt_d    = wait_cnt_q + 1'b1;
    end else begin
      state_d    = S_RUN;
      wait_cnt_d = '0;
      // A timed-out access advances as if ready but its result is dropped.
      if (timeout_hit) begin
        timeout_err_d = 1'b1;
        ctrl.flush[0] = 1'b1;
      end
      if (branch_taken) begin
        ctrl.pc_src     = 1'b1;
        ctrl.flush[3:1] = 3'b111;
      end else if (lu_stall) begin
        ctrl.pc_en    = 1'b0;
        ctrl.en[3]    = 1'b0;
        ctrl.flush[2] = 1'b1;
      end
    end
    if (rst) begin
      ctrl = CTRL_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign pc_src       = ctrl.pc_src;
  assign if_id_en     = ctrl.en[3];
  assign id_ex_en     = ctrl.en[2];
  assign ex_mem_en    = ctrl.en[1];
  assign mem_wb_en    = ctrl.en[0];
  assign if_id_flush  = ctrl.flush[3];
  assign id_ex_flush  = ctrl.flush[2];
  assign ex_mem_flush = ctrl.flush[1];
  assign mem_wb_flush = ctrl.flush[0];
  assign timeout_err  = timeout_err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      if (lu_stall)     stall_cnt_q   <= sat_inc(stall_cnt_q);
      if (branch_taken) flush_cnt_q   <= sat_inc(flush_cnt_q);
      if (mem_wait)     memwait_cnt_q <= sat_inc(memwait_cnt_q);
    end
  end

  assign stall_cycles   = stall_cnt_q;
  assign flush_events   = flush_cnt_q;
  assign memwait_cycles = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, id_ex_wreg;
  logic       id_uses_rt, id_ex_memread, ex_mem_branch, ex_mem_zero;
  logic       dmem_req, dmem_ready;
  logic       pc_en, pc_src, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, timeout_err;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_events, memwait_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Expected bundles: {pc_en, pc_src, en[IF_ID,ID_EX,EX_MEM,MEM_WB], flush[same order]}
  localparam logic [9:0] E_IDLE = 10'b0_0_0000_0000;
  localparam logic [9:0] E_RUN  = 10'b1_0_1111_0000;
  localparam logic [9:0] E_LU   = 10'b0_0_0111_0100;
  localparam logic [9:0] E_BR   = 10'b1_1_1111_1110;
  localparam logic [9:0] E_MW   = 10'b0_0_0001_0001;
  localparam logic [9:0] E_TO   = 10'b1_0_1111_0001;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .id_ex_memread (id_ex_memread),
    .id_ex_wreg    (id_ex_wreg),
    .ex_mem_branch (ex_mem_branch),
    .ex_mem_zero   (ex_mem_zero),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .pc_en         (pc_en),
    .pc_src        (pc_src),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_flush  (ex_mem_flush),
    .mem_wb_flush  (mem_wb_flush),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles  (stall_cycles),
    .flush_events  (flush_events),
    .memwait_cycles(memwait_cycles),
`endif
    .timeout_err   (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic memrd, input logic [4:0] wreg, input logic [4:0] rs,
                        input logic [4:0] rt, input logic use_rt, input logic br,
                        input logic zero, input logic req, input logic rdy);
    id_ex_memread = memrd; id_ex_wreg = wreg; id_rs = rs; id_rt = rt;
    id_uses_rt = use_rt; ex_mem_branch = br; ex_mem_zero = zero;
    dmem_req = req; dmem_ready = rdy;
  endtask

  // Check outputs for the inputs currently applied, then advance one cycle.
  task automatic cyc(input string tag, input logic [9:0] exp_ctrl, input logic exp_to);
    @(negedge clk);
    chk(tag, {22'd0, pc_en, pc_src, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, {22'd0, exp_ctrl});
    chk({tag, "_terr"}, {31'd0, timeout_err}, {31'd0, exp_to});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    cyc("reset", E_IDLE, 1'b0);
`ifdef PIPE_PERF_CNT_EN
    chk("rst_stall_cnt", {16'd0, stall_cycles}, 32'd0);
    chk("rst_flush_cnt", {16'd0, flush_events}, 32'd0);
    chk("rst_mw_cnt", {16'd0, memwait_cycles}, 32'd0);
`endif
    rst = 1'b0;
    idle_in();
    cyc("idle", E_RUN, 1'b0);

    // Load-use on rs, then on rt, then the r0 and rt-unused exemptions
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs", E_LU, 1'b0);
    idle_in();
    cyc("lu_after", E_RUN, 1'b0);
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_r0", E_RUN, 1'b0);
    set_in(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_rt", E_LU, 1'b0);
    set_in(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_rt_unused", E_RUN, 1'b0);

    // Branch taken vs not taken
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("br_taken", E_BR, 1'b0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("br_not_taken", E_RUN, 1'b0);

    // Three wait cycles then ready
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("mw_wait", E_MW, 1'b0);
    dmem_ready = 1'b1;
    cyc("mw_ready", E_RUN, 1'b0);
    dmem_req = 1'b0; dmem_ready = 1'b0;
    cyc("mw_after", E_RUN, 1'b0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("mw_same_cycle_ready", E_RUN, 1'b0);

    // Wait coincident with branch and load-use; ready cycle shows branch only
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("prio_wait1", E_MW, 1'b0);
    cyc("prio_wait2", E_MW, 1'b0);
    dmem_ready = 1'b1;
    cyc("prio_ready", E_BR, 1'b0);
    idle_in();
    cyc("prio_after", E_RUN, 1'b0);

    // Timeout after 4 wait cycles; flag sticky; FSM back in S_RUN
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("to_wait", E_MW, 1'b0);
    cyc("to_hit", E_TO, 1'b0);
    dmem_req = 1'b0;
    cyc("to_after", E_RUN, 1'b1);
    dmem_req = 1'b1;
    cyc("to_rewait1", E_MW, 1'b1);
    cyc("to_rewait2", E_MW, 1'b1);

    // Reset mid-wait clears the flag and abandons the access
    rst = 1'b1;
    cyc("rst_midwait", E_IDLE, 1'b1);
    cyc("rst_hold", E_IDLE, 1'b0);
    rst = 1'b0;
    dmem_req = 1'b0;
    cyc("post_rst", E_RUN, 1'b0);
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc("post_rst_wait", E_MW, 1'b0);
    cyc("post_rst_to", E_TO, 1'b0);
    idle_in();
    cyc("post_rst_end", E_RUN, 1'b1);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_mw_cnt", {16'd0, memwait_cycles}, 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF_ID, ID_EX, EX_MEM, MEM_WB registers plus PC).
- Detects load-use hazards in ID and branch-taken in MEM.
- Handles data-memory wait states in MEM.
- Drives per-register enables and flushes (flush = synchronous clear into a bubble) so that every pipeline register is sequenced from one place.

Parameters:
- REG_W, 5, register-index width.
- MEM_TIMEOUT, 16, max consecutive dmem wait cycles before timeout_err.
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs  in  REG_W  rs index of the instruction in ID
- id_rt  in  REG_W  rt index of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- id_ex_memread  in  1  instruction in EX is a load
- id_ex_wreg  in  REG_W  destination register of the EX instruction
- ex_mem_branch  in  1  MEM-stage instruction is a branch
- ex_mem_zero  in  1  MEM-stage zero flag
- dmem_req  in  1  MEM stage accessing data memory this cycle
- dmem_ready  in  1  data memory completes this cycle
- pc_en  out  1  PC update enable
- pc_src  out  1  1 = load branch target from EX_MEM
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  bubble inserts
- timeout_err  out  1  sticky dmem timeout flag

Behaviour:
- FSM states: S_RUN, S_MEM_WAIT. State register and counters are sequential. Control outputs are combinational from state plus current inputs.
- Reset:
  - While rst=1: all *_en=0, all *_flush=0, pc_src=0.
  - At the first edge with rst=1: state=S_RUN, wait_cnt=0, timeout_err=0.
- Default in S_RUN: all enables 1, all flushes 0, pc_src=0.
- Priority:
  1. Memory wait.
  2. Branch taken.
  3. Load-use.
  4. Normal.
- Memory wait:
  - Trigger: dmem_req=1 and dmem_ready=0.
  - Outputs: pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_flush=1.
  - State goes to S_MEM_WAIT and wait_cnt increments.
  - Stays in S_MEM_WAIT while dmem_ready=0.
  - When dmem_ready=1: that cycle is a normal S_RUN cycle (branch and load-use are evaluated), and the next state is S_RUN with wait_cnt=0.
  - Same-cycle ready (dmem_req=1 with dmem_ready=1) causes no stall.
- Timeout:
  - When wait_cnt reaches MEM_TIMEOUT-1 while still waiting, timeout_err is set (sticky until rst).
  - The FSM then forces a return to S_RUN as if ready.
  - The MEM instruction is dropped: mem_wb_flush=1 for that cycle.
- Branch taken:
  - Condition: ex_mem_branch and ex_mem_zero, and no memory wait.
  - Outputs: pc_src=1, pc_en=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
  - Three wrong-path instructions are squashed; MEM_WB captures normally.
  - Load-use is ignored in the same cycle because the ID instruction is squashed.
- Load-use:
  - Condition: id_ex_memread, id_ex_wreg≠0, and (id_ex_wreg==id_rs or (id_uses_rt and id_ex_wreg==id_rt)).
  - Outputs: pc_en=0, if_id_en=0, id_ex_flush=1.
  - Exactly a 1-cycle bubble; the condition clears naturally the next cycle.
- Enable and flush on the same register: flush wins (register cleared).
- Reset mid-wait: the FSM returns to S_RUN and the pending access is abandoned.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: adds outputs stall_cycles, flush_events, memwait_cycles (CNT_W each).
  - Reset 0.
  - Incremented respectively on load-use stall cycles, branch-flush cycles, and memory-wait cycles.
  - Saturate at all-ones.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum (S_RUN, S_MEM_WAIT);
  - REG_W;
  - control-bundle struct {pc_en, pc_src, en[3:0], flush[3:0]}.
- One natural sub-module: pipe_hazard_detect, purely combinational load-use comparator. Reusable later for a forwarding unit.
- The FSM, timeout logic and perf counters stay in the top level.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_wreg=5, id_rs=5 for one cycle → pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; all enables 1 on the next cycle. Repeat with id_ex_wreg=0 → no stall.
- Branch: ex_mem_branch=1, ex_mem_zero=1 → pc_src=1, if_id/id_ex/ex_mem_flush=1, mem_wb_en=1; with ex_mem_zero=0 → no flush.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 → 3 cycles of pc/if_id/id_ex/ex_mem_en=0 with mem_wb_flush=1; 4th cycle normal; state back to S_RUN.
- Priority: memory wait coincident with branch taken and load-use → only the memory-wait outputs are seen; on the ready cycle the branch flush is applied and the load-use is suppressed.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 → timeout_err=1 after 4 wait cycles, FSM returns to S_RUN, flag stays 1 until rst.
- Reset mid-wait: assert rst during S_MEM_WAIT → all enables 0 during reset; after release state=S_RUN, timeout_err=0, perf counters 0 (PIPE_PERF_CNT_EN build).
